// File: rtl/apuf_pkg.sv
// apuf_pkg: shared FSM states, LFSR taps and challenge stepping for the arbiter-PUF sequencer
package apuf_pkg;
  localparam int CHAL_W_DEF = 64;
  localparam logic [CHAL_W_DEF-1:0] LFSR_TAPS = 64'hD800_0000_0000_0000;
  typedef enum logic [2:0] {S_IDLE, S_ARM, S_FIRE, S_RELAX, S_VOTE, S_OUT, S_NEXT} state_t;
  function automatic logic [CHAL_W_DEF-1:0] lfsr_next(input logic [CHAL_W_DEF-1:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
  endfunction
endpackage

// File: rtl/apuf_sync2.sv
// apuf_sync2: two-flop synchronizer; clk/rst (sync, active-high), d async in, q synchronized out
module apuf_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic r_meta, r_q;
  always_ff @(posedge clk) begin
    r_meta <= rst ? 1'b0 : d;
    r_q    <= rst ? 1'b0 : r_meta;
  end
  assign q = r_q;
endmodule

// File: rtl/apuf_crp_sequencer.sv
// apuf_crp_sequencer: drives arbiter-PUF challenges/trigger, collects responses, emits voted CRPs
// Ports: clk, rst (sync, active-high), run (level enable); c/tigSignal to the PUF;
//   respReady/respBit from the PUF (async, synchronized here); crp_valid/crp_ready handshake
//   carrying crp_chal, crp_resp, crp_ones, crp_timeout.
// APUF_SEQ_MAJORITY_EN: when defined, NUM_EVAL evaluations are majority-voted; otherwise one per CRP.
module apuf_crp_sequencer
  import apuf_pkg::*;
#(
  parameter int CHAL_W = CHAL_W_DEF,
  parameter int NUM_EVAL = 15,
  parameter int SETTLE_CYC = 4,
  parameter int TIMEOUT_CYC = 255,
  parameter logic [CHAL_W-1:0] LFSR_SEED = CHAL_W'(1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  output logic [CHAL_W-1:0] c,
  output logic              tigSignal,
  input  logic              respReady,
  input  logic              respBit,
  output logic              crp_valid,
  input  logic              crp_ready,
  output logic [CHAL_W-1:0] crp_chal,
  output logic              crp_resp,
  output logic [7:0]        crp_ones,
  output logic              crp_timeout
);
  localparam logic [CHAL_W-1:0] SEED = (LFSR_SEED == '0) ? CHAL_W'(1) : LFSR_SEED;
  localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYC - 1);
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYC - 1);
`ifdef APUF_SEQ_MAJORITY_EN
  localparam int OW = 8;
  localparam logic [7:0] EVAL_LAST = 8'(NUM_EVAL - 1);
  localparam logic [7:0] HALF = 8'(NUM_EVAL / 2);
  logic [7:0] r_ev;
`else
  localparam int OW = 1;
  localparam int unused_num_eval = NUM_EVAL;
`endif
  state_t            r_state;
  logic [CHAL_W-1:0] r_c, r_chal;
  logic [15:0]       r_cnt;
  logic [OW-1:0]     r_ones;
  logic [7:0]        r_ones_o;
  logic              r_tig, r_valid, r_resp, r_to, r_to_o;
  logic              w_rdy, w_bit;
  apuf_sync2 u_sync_rdy (.clk(clk), .rst(rst), .d(respReady), .q(w_rdy));
  apuf_sync2 u_sync_bit (.clk(clk), .rst(rst), .d(respBit), .q(w_bit));
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_c      <= SEED;
      r_tig    <= 1'b0;
      r_valid  <= 1'b0;
      r_chal   <= '0;
      r_resp   <= 1'b0;
      r_ones_o <= '0;
      r_to_o   <= 1'b0;
      r_cnt    <= '0;
      r_ones   <= '0;
      r_to     <= 1'b0;
`ifdef APUF_SEQ_MAJORITY_EN
      r_ev     <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: if (run) begin
          r_state <= S_ARM;
          r_cnt   <= '0;
        end
        S_ARM: if (r_cnt == SETTLE_LAST) begin
          r_state <= S_FIRE;
          r_tig   <= 1'b1;
          r_cnt   <= '0;
        end else r_cnt <= r_cnt + 16'd1;
        // only the first ready cycle is sampled since FIRE is left at once
        S_FIRE: if (w_rdy || r_cnt == TMO_LAST) begin
          r_ones  <= r_ones + OW'(w_rdy & w_bit);
          r_to    <= r_to | ~w_rdy;
          r_tig   <= 1'b0;
          r_cnt   <= '0;
          r_state <= S_RELAX;
        end else r_cnt <= r_cnt + 16'd1;
        S_RELAX: if (!w_rdy || r_cnt == TMO_LAST) begin
          r_cnt <= '0;
          r_to  <= r_to | w_rdy;
`ifdef APUF_SEQ_MAJORITY_EN
          r_ev    <= r_ev + 8'd1;
          r_state <= (r_ev == EVAL_LAST) ? S_VOTE : S_ARM;
`else
          r_valid  <= 1'b1;
          r_chal   <= r_c;
          r_resp   <= r_ones[0];
          r_ones_o <= 8'(r_ones);
          r_to_o   <= r_to | w_rdy;
          r_state  <= S_OUT;
`endif
        end else r_cnt <= r_cnt + 16'd1;
`ifdef APUF_SEQ_MAJORITY_EN
        S_VOTE: begin
          r_valid  <= 1'b1;
          r_chal   <= r_c;
          r_resp   <= r_ones > HALF;
          r_ones_o <= r_ones;
          r_to_o   <= r_to;
          r_state  <= S_OUT;
        end
`endif
        S_OUT: if (crp_ready) begin
          r_valid <= 1'b0;
          r_state <= S_NEXT;
        end
        S_NEXT: begin
          r_c     <= lfsr_next(r_c);
          r_ones  <= '0;
          r_to    <= 1'b0;
          r_cnt   <= '0;
`ifdef APUF_SEQ_MAJORITY_EN
          r_ev    <= '0;
`endif
          r_state <= run ? S_ARM : S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
  assign c           = r_c;
  assign tigSignal   = r_tig;
  assign crp_valid   = r_valid;
  assign crp_chal    = r_chal;
  assign crp_resp    = r_resp;
  assign crp_ones    = r_ones_o;
  assign crp_timeout = r_to_o;
endmodule

// File: tb/tb_apuf_crp_sequencer.sv
// tb_apuf_crp_sequencer: directed checks of the CRP sequencer against a simple arbiter-PUF model
module tb_apuf_crp_sequencer;
`ifdef APUF_SEQ_MAJORITY_EN
  localparam int NE = 15;
  localparam logic [14:0] MASK = 15'h7FFF;
`else
  localparam int NE = 1;
  localparam logic [14:0] MASK = 15'h0001;
`endif
  logic        clk = 1'b0, rst = 1'b1, run = 1'b0, crp_ready = 1'b0;
  logic        respReady = 1'b0, respBit = 1'b0;
  logic [63:0] c, crp_chal;
  logic        tigSignal, crp_valid, crp_resp, crp_timeout;
  logic [7:0]  crp_ones;
  logic [14:0] pat = '0;
  logic        puf_on = 1'b0;
  int          idx = 0, dly = 0, n_cmp = 0, n_bad = 0, c_viol = 0;
  logic [63:0] prev_c = '0;
  apuf_crp_sequencer #(.CHAL_W(64), .NUM_EVAL(15), .SETTLE_CYC(4), .TIMEOUT_CYC(10),
                       .LFSR_SEED(64'h0)) dut (
    .clk(clk), .rst(rst), .run(run), .c(c), .tigSignal(tigSignal),
    .respReady(respReady), .respBit(respBit), .crp_valid(crp_valid), .crp_ready(crp_ready),
    .crp_chal(crp_chal), .crp_resp(crp_resp), .crp_ones(crp_ones), .crp_timeout(crp_timeout));
  always #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    #1;
    if (tigSignal !== 1'b1) begin
      respReady = 1'b0;
      respBit = 1'b0;
      dly = 0;
    end else if (puf_on && !respReady) begin
      if (dly == 2) begin
        respReady = 1'b1;
        respBit = (idx < 15) ? pat[idx] : 1'b0;
        idx++;
      end else dly++;
    end
  end
  always @(negedge clk) begin
    if (tigSignal === 1'b1 && c !== prev_c) c_viol++;
    prev_c = c;
  end
  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask
  task automatic run_crp(input string tag, input logic [14:0] p, input logic on, input int stall,
                         input logic [63:0] e_chal, input logic e_to);
    int n, e_ones, chg;
    logic [63:0] c0, ch0;
    logic [7:0] o0;
    logic r0, t0;
    e_ones = on ? $countones(p & MASK) : 0;
    pat = p;
    idx = 0;
    puf_on = on;
    crp_ready = (stall == 0);
    run = 1'b1;
    n = 0;
    while (crp_valid !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    run = 1'b0;
    chk({tag, "_valid"}, {63'b0, crp_valid}, 64'd1);
    chk({tag, "_chal"}, crp_chal, e_chal);
    chk({tag, "_ones"}, {56'b0, crp_ones}, 64'(e_ones));
    chk({tag, "_resp"}, {63'b0, crp_resp}, {63'b0, e_ones > NE / 2});
    chk({tag, "_tmo"}, {63'b0, crp_timeout}, {63'b0, e_to});
    if (stall > 0) begin
      c0 = c; ch0 = crp_chal; o0 = crp_ones; r0 = crp_resp; t0 = crp_timeout;
      chg = 0;
      for (int i = 0; i < stall; i++) begin
        @(negedge clk);
        if (crp_valid !== 1'b1 || c !== c0 || crp_chal !== ch0 || crp_ones !== o0 ||
            crp_resp !== r0 || crp_timeout !== t0 || tigSignal !== 1'b0) chg++;
      end
      chk({tag, "_stall"}, 64'(chg), 64'd0);
      crp_ready = 1'b1;
    end
    @(negedge clk);
    chk({tag, "_pulse"}, {63'b0, crp_valid}, 64'd0);
    crp_ready = 1'b0;
    repeat (3) @(negedge clk);
  endtask
  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk("rst_c", c, 64'h1);
    chk("rst_tig", {63'b0, tigSignal}, 64'd0);
    chk("rst_valid", {63'b0, crp_valid}, 64'd0);
    chk("rst_payload", {crp_chal[54:0], crp_ones, crp_resp}, 64'd0);
    chk("rst_tmo", {63'b0, crp_timeout}, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    run_crp("all1", 15'h7FFF, 1'b1, 0, 64'h0000_0000_0000_0001, 1'b0);
    run_crp("maj8", 15'h5555, 1'b1, 0, 64'hD800_0000_0000_0000, 1'b0);
    run_crp("maj7", 15'h2AAA, 1'b1, 0, 64'h6C00_0000_0000_0000, 1'b0);
    run_crp("tmo", 15'h7FFF, 1'b0, 0, 64'h3600_0000_0000_0000, 1'b1);
    run_crp("post_tmo", 15'h7FFF, 1'b1, 0, 64'h1B00_0000_0000_0000, 1'b0);
    run_crp("stall", 15'h0F0F, 1'b1, 20, 64'h0D80_0000_0000_0000, 1'b0);
    pat = 15'h7FFF;
    idx = 0;
    puf_on = 1'b1;
    run = 1'b1;
    n = 0;
    while (tigSignal !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("fire_seen", {63'b0, tigSignal}, 64'd1);
    @(negedge clk);
    rst = 1'b1;
    run = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_rst_tig", {63'b0, tigSignal}, 64'd0);
    chk("mid_rst_valid", {63'b0, crp_valid}, 64'd0);
    chk("mid_rst_c", c, 64'h1);
    chk("mid_rst_ones", {56'b0, crp_ones}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_crp("after_rst", 15'h7FFF, 1'b1, 0, 64'h0000_0000_0000_0001, 1'b0);
    chk("c_in_fire", 64'(c_viol), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
